axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Two-master AXI4 read-channel arbiter sharing one read-only slave port (framebuffer memory).
//  Master 0 is video scanout (latency-critical bursts); master 1 is the CPU/bus bridge.
//  One transaction is outstanding at a time, so no AXI IDs are needed.
//  Sits between the VROOMSoC read masters and the frmbuf_m_axi_ar*/r* port toward the memory slave.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  read data width
//  PRIO_M0   1   1: m0 has strict priority subject to the starvation guard; 0: round-robin
//  MAX_WAIT  4   PRIO_M0=1 only: after m0 wins this many consecutive grants while m1 is pending, m1 gets the next grant
// PORTS
//  clk_i                        in   1       clock
//  rst_ni                       in   1       asynchronous reset, active low
//  m{0,1}_axi_arvalid/arready   in/out 1     AR handshake per master
//  m{0,1}_axi_araddr            in   ADDR_W  read address
//  m{0,1}_axi_arlen             in   8       burst length - 1
//  m{0,1}_axi_arsize            in   3       beat size
//  m{0,1}_axi_arburst           in   2       burst type
//  m{0,1}_axi_rvalid/rready     out/in 1     R handshake per master
//  m{0,1}_axi_rlast             out  1       last beat
//  m{0,1}_axi_rdata             out  DATA_W  read data
//  m{0,1}_axi_rresp             out  2       read response
//  s_axi_ar{valid,addr,len,size,burst} out   -       to slave; widths as above
//  s_axi_arready                in   1       from slave
//  s_axi_r{valid,last,data,resp} in   -       from slave
//  s_axi_rready                 out  1       to slave
//  grant_o                      out  2       one-hot current owner (debug/observe)
// BEHAVIOUR
//  FSM states: IDLE, ADDR, DATA.
//  Reset (rst_ni=0, async): state=IDLE, grant_o=0, all arready/rvalid/s_axi_arvalid/s_axi_rready=0,
//    wait counter=0, round-robin pointer=m0.
//  IDLE: arbitrate among asserted m*_arvalid.
//    - Registered grant; m*_arready is never combinationally asserted in IDLE.
//    - Capture the winner's AR fields into a holding register.
//    - Go to ADDR on the next cycle.
//  ADDR: s_axi_arvalid=1 with the held fields. On s_axi_arready=1, pulse the winner's m_arready
//    for that same cycle (the master's handshake). Fields are stable because the master holds
//    arvalid until arready. Then go to DATA.
//  DATA: pass-through. s_axi_rready=winner rready; winner rvalid=s_axi_rvalid;
//    rdata/rresp/rlast driven to both masters; non-owner rvalid=0.
//    On s_axi_rvalid&&s_axi_rready&&s_axi_rlast, go to IDLE.
//  Minimum turnaround: 1 idle cycle between the last R beat and the next AR to the slave.
//    A new grant is never issued in the rlast cycle.
//  Arbitration:
//    - PRIO_M0=1: m0 wins unless m1 is pending and waitcnt==MAX_WAIT.
//      waitcnt increments on each m0 grant while m1_arvalid=1, clears on any m1 grant,
//      and saturates at MAX_WAIT.
//    - PRIO_M0=0: on simultaneous requests the master not granted last wins; the pointer updates on every grant.
//  Single requester: always granted, with no bubble beyond the fixed IDLE->ADDR cycle.
//  arlen=0: a single beat where rlast is on the first beat; handled identically.
//  Deasserting arvalid before arready is an AXI protocol violation by the master.
//    Behaviour is undefined and no recovery is attempted.
//  Reset mid-burst: the FSM returns to IDLE immediately and the slave must be reset concurrently.
//  Slave rresp is passed through unmodified. The arbiter never generates an error response.
// CONFIGURATION
//  AXI_RD_ARB_PERFCNT_EN defined:
//    - Adds outputs perf_gnt0_o[31:0], perf_gnt1_o[31:0] (grants per master) and
//      perf_stall_o[31:0] (cycles with arvalid pending but not granted, summed over masters).
//    - All counters wrap, are reset to 0, and are read-only.
//  Not defined: these ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//  Package axi_rd_arb_pkg:
//    - state enum {IDLE, ADDR, DATA}
//    - ar_req_t struct (addr, len, size, burst)
//    - AXI_BURST_INCR/FIXED/WRAP constants
//  Sub-module axi_rd_arb_pick: combinational 2-way pick with priority/round-robin/starvation inputs.
//    It returns a one-hot winner. Counter state stays in the top level.
// TESTING
//  1. Only m1 issues araddr=C0000010, arlen=3 -> s_axi_arvalid 1 cycle after request;
//     4 beats reach m1 with rlast on beat 4; m0 rvalid stays 0.
//  2. PRIO_M0=1, MAX_WAIT=4, m0 and m1 both request back-to-back ->
//     grant order m0,m0,m0,m0,m1,m0,...
//  3. PRIO_M0=0, both request continuously -> grants alternate m0,m1,m0,m1.
//  4. Slave holds arready=0 for 5 cycles -> held AR fields stable; m_arready pulses exactly once, with s_axi_arready.
//  5. Winner drops rready for 3 cycles mid-burst -> s_axi_rready=0 during the stall; no beat lost or duplicated.
//  6. rst_ni asserted during DATA beat 2 of 8 -> all outputs 0 asynchronously; after release, a fresh m0 request completes normally.
//     With AXI_RD_ARB_PERFCNT_EN: counters read 0, then perf_gnt0_o=1.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arb_pkg
//  Description : Shared types and constants for the two-master AXI4 read
//                arbiter (FSM state encoding, held AR request, burst codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // Width of the address held in ar_req_t; must be at least the top ADDR_W
    localparam int AR_ADDR_W = 32;

    // AXI4 burst type encodings
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // AR channel fields captured from the winning master
    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ar_req_t;

endpackage : axi_rd_arb_pkg
`default_nettype wire

// File: rtl/axi_rd_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arb_pick
//  Description : Combinational two-way pick. Returns a one-hot winner from
//                the request vector using either fixed m0 priority with a
//                starvation override, or round-robin on a pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arb_pick (
    input  logic [1:0] req,      // {m1, m0} pending AR requests
    input  logic       prio_m0,  // 1: m0 priority mode, 0: round-robin
    input  logic       starve,   // m1 has waited the maximum number of grants
    input  logic       rr_ptr,   // round-robin preference: 0 = m0, 1 = m1
    output logic [1:0] gnt       // one-hot winner, zero when nothing pending
);

    // Resolve the winner; contention is the only case needing a policy
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (prio_m0) begin
                    gnt = starve ? 2'b10 : 2'b01;
                end else begin
                    gnt = rr_ptr ? 2'b10 : 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule : axi_rd_arb_pick
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter
//  Description : Two-master AXI4 read-channel arbiter in front of a single
//                read-only framebuffer slave. One transaction outstanding at
//                a time. m0 = video scanout, m1 = CPU/bus bridge.
//                Optional macro AXI_RD_ARB_PERFCNT_EN adds grant and stall
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int PRIO_M0  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // master 0
    input  logic              m0_axi_arvalid,
    output logic              m0_axi_arready,
    input  logic [ADDR_W-1:0] m0_axi_araddr,
    input  logic [7:0]        m0_axi_arlen,
    input  logic [2:0]        m0_axi_arsize,
    input  logic [1:0]        m0_axi_arburst,
    output logic              m0_axi_rvalid,
    input  logic              m0_axi_rready,
    output logic              m0_axi_rlast,
    output logic [DATA_W-1:0] m0_axi_rdata,
    output logic [1:0]        m0_axi_rresp,
    // master 1
    input  logic              m1_axi_arvalid,
    output logic              m1_axi_arready,
    input  logic [ADDR_W-1:0] m1_axi_araddr,
    input  logic [7:0]        m1_axi_arlen,
    input  logic [2:0]        m1_axi_arsize,
    input  logic [1:0]        m1_axi_arburst,
    output logic              m1_axi_rvalid,
    input  logic              m1_axi_rready,
    output logic              m1_axi_rlast,
    output logic [DATA_W-1:0] m1_axi_rdata,
    output logic [1:0]        m1_axi_rresp,
    // slave
    output logic              s_axi_arvalid,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic [7:0]        s_axi_arlen,
    output logic [2:0]        s_axi_arsize,
    output logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arready,
    input  logic              s_axi_rvalid,
    input  logic              s_axi_rlast,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp,
    output logic              s_axi_rready,
    // observe
    output logic [1:0]        grant_o
`ifdef AXI_RD_ARB_PERFCNT_EN
    ,
    output logic [31:0]       perf_gnt0_o,
    output logic [31:0]       perf_gnt1_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ADDR = ADDR;
    localparam logic [1:0] S_DATA = DATA;

    localparam logic           PRIO_EN  = (PRIO_M0 != 0);
    localparam int             CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [1:0]       state_q;
    logic [1:0]       grant_q;
    ar_req_t          hold_q;
    ar_req_t          sel_req;
    logic [CNT_W-1:0] waitcnt_q;
    logic             rr_ptr_q;
    logic [1:0]       req;
    logic [1:0]       pick_gnt;
    logic             starve;
    logic             arb_fire;
    logic             ar_hs;
    logic             r_done;

    assign req      = {m1_axi_arvalid, m0_axi_arvalid};
    assign starve   = (waitcnt_q == WAIT_MAX);
    assign arb_fire = (state_q == S_IDLE) && (|req);
    assign ar_hs    = (state_q == S_ADDR) && s_axi_arready;
    assign r_done   = (state_q == S_DATA) && s_axi_rvalid && s_axi_rready && s_axi_rlast;

    axi_rd_arb_pick u_pick (
        .req     (req),
        .prio_m0 (PRIO_EN),
        .starve  (starve),
        .rr_ptr  (rr_ptr_q),
        .gnt     (pick_gnt)
    );

    // Select the AR fields of the master the picker chose
    always_comb begin
        sel_req       = '0;
        sel_req.addr  = AR_ADDR_W'(pick_gnt[1] ? m1_axi_araddr : m0_axi_araddr);
        sel_req.len   = pick_gnt[1] ? m1_axi_arlen   : m0_axi_arlen;
        sel_req.size  = pick_gnt[1] ? m1_axi_arsize  : m0_axi_arsize;
        sel_req.burst = pick_gnt[1] ? m1_axi_arburst : m0_axi_arburst;
    end

    // Main FSM: registered grant in IDLE, address hand-off, data pass-through
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_fire) begin
                        state_q <= S_ADDR;
                        grant_q <= pick_gnt;
                        hold_q  <= sel_req;
                    end
                end
                S_ADDR: begin
                    if (ar_hs) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Returning to IDLE here forces one idle cycle before the next AR
                    if (r_done) begin
                        state_q <= S_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // Fairness state: starvation counter for m1 and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waitcnt_q <= '0;
            rr_ptr_q  <= 1'b0;
        end else if (arb_fire) begin
            // After an m0 grant prefer m1 next, and vice versa
            rr_ptr_q <= pick_gnt[0];
            if (pick_gnt[1]) begin
                waitcnt_q <= '0;
            end else if (m1_axi_arvalid && (waitcnt_q != WAIT_MAX)) begin
                waitcnt_q <= waitcnt_q + 1'b1;
            end
        end
    end

    // Slave AR channel driven from the holding register
    assign s_axi_arvalid  = (state_q == S_ADDR);
    assign s_axi_araddr   = ADDR_W'(hold_q.addr);
    assign s_axi_arlen    = hold_q.len;
    assign s_axi_arsize   = hold_q.size;
    assign s_axi_arburst  = hold_q.burst;

    // Master arready mirrors the slave handshake for the owner only
    assign m0_axi_arready = ar_hs && grant_q[0];
    assign m1_axi_arready = ar_hs && grant_q[1];

    // R channel: ready from owner, valid to owner only, payload broadcast
    assign s_axi_rready   = (state_q == S_DATA) &&
                            ((grant_q[0] && m0_axi_rready) || (grant_q[1] && m1_axi_rready));
    assign m0_axi_rvalid  = (state_q == S_DATA) && grant_q[0] && s_axi_rvalid;
    assign m1_axi_rvalid  = (state_q == S_DATA) && grant_q[1] && s_axi_rvalid;
    assign m0_axi_rlast   = s_axi_rlast;
    assign m1_axi_rlast   = s_axi_rlast;
    assign m0_axi_rdata   = s_axi_rdata;
    assign m1_axi_rdata   = s_axi_rdata;
    assign m0_axi_rresp   = s_axi_rresp;
    assign m1_axi_rresp   = s_axi_rresp;

    assign grant_o        = grant_q;

`ifdef AXI_RD_ARB_PERFCNT_EN
    logic [31:0] perf_gnt0_q;
    logic [31:0] perf_gnt1_q;
    logic [31:0] perf_stall_q;
    logic [1:0]  stall_vec;

    // A master stalls when it requests but neither owns nor is being granted
    always_comb begin
        stall_vec = req & ~grant_q & ~(arb_fire ? pick_gnt : 2'b00);
    end

    // Free-running wrapping counters of grants and stalled request cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_gnt0_q  <= '0;
            perf_gnt1_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (arb_fire) begin
                perf_gnt0_q <= perf_gnt0_q + {31'b0, pick_gnt[0]};
                perf_gnt1_q <= perf_gnt1_q + {31'b0, pick_gnt[1]};
            end
            perf_stall_q <= perf_stall_q + {31'b0, stall_vec[0]} + {31'b0, stall_vec[1]};
        end
    end

    assign perf_gnt0_o  = perf_gnt0_q;
    assign perf_gnt1_o  = perf_gnt1_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_arbiter
//  Description : Directed self-checking bench for axi_rd_arbiter. Two
//                instances share all inputs: one in m0-priority mode, one in
//                round-robin mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // master-side stimulus
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    // slave-side stimulus
    logic        s_arready, s_rvalid, s_rlast;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    // priority-mode instance outputs
    logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata, s_araddr;
    logic [1:0]  m0_rresp, m1_rresp, s_arburst, grant;
    logic        s_arvalid, s_rready;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;

    // round-robin instance outputs
    logic        rr_m0_arready, rr_m0_rvalid, rr_m0_rlast, rr_m1_arready, rr_m1_rvalid, rr_m1_rlast;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_araddr;
    logic [1:0]  rr_m0_rresp, rr_m1_rresp, rr_s_arburst, rr_grant;
    logic        rr_s_arvalid, rr_s_rready;
    logic [7:0]  rr_s_arlen;
    logic [2:0]  rr_s_arsize;

`ifdef AXI_RD_ARB_PERFCNT_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_stall;
    logic [31:0] rr_perf_gnt0, rr_perf_gnt1, rr_perf_stall;
`endif

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_M0(1), .MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready), .m0_axi_araddr(m0_araddr),
        .m0_axi_arlen(m0_arlen), .m0_axi_arsize(m0_arsize), .m0_axi_arburst(m0_arburst),
        .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready), .m0_axi_rlast(m0_rlast),
        .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp),
        .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready), .m1_axi_araddr(m1_araddr),
        .m1_axi_arlen(m1_arlen), .m1_axi_arsize(m1_arsize), .m1_axi_arburst(m1_arburst),
        .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready), .m1_axi_rlast(m1_rlast),
        .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp),
        .s_axi_arvalid(s_arvalid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arready(s_arready),
        .s_axi_rvalid(s_rvalid), .s_axi_rlast(s_rlast), .s_axi_rdata(s_rdata),
        .s_axi_rresp(s_rresp), .s_axi_rready(s_rready),
        .grant_o(grant)
`ifdef AXI_RD_ARB_PERFCNT_EN
        , .perf_gnt0_o(perf_gnt0), .perf_gnt1_o(perf_gnt1), .perf_stall_o(perf_stall)
`endif
    );

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_M0(0), .MAX_WAIT(4)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(rr_m0_arready), .m0_axi_araddr(m0_araddr),
        .m0_axi_arlen(m0_arlen), .m0_axi_arsize(m0_arsize), .m0_axi_arburst(m0_arburst),
        .m0_axi_rvalid(rr_m0_rvalid), .m0_axi_rready(m0_rready), .m0_axi_rlast(rr_m0_rlast),
        .m0_axi_rdata(rr_m0_rdata), .m0_axi_rresp(rr_m0_rresp),
        .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(rr_m1_arready), .m1_axi_araddr(m1_araddr),
        .m1_axi_arlen(m1_arlen), .m1_axi_arsize(m1_arsize), .m1_axi_arburst(m1_arburst),
        .m1_axi_rvalid(rr_m1_rvalid), .m1_axi_rready(m1_rready), .m1_axi_rlast(rr_m1_rlast),
        .m1_axi_rdata(rr_m1_rdata), .m1_axi_rresp(rr_m1_rresp),
        .s_axi_arvalid(rr_s_arvalid), .s_axi_araddr(rr_s_araddr), .s_axi_arlen(rr_s_arlen),
        .s_axi_arsize(rr_s_arsize), .s_axi_arburst(rr_s_arburst), .s_axi_arready(s_arready),
        .s_axi_rvalid(s_rvalid), .s_axi_rlast(s_rlast), .s_axi_rdata(s_rdata),
        .s_axi_rresp(s_rresp), .s_axi_rready(rr_s_rready),
        .grant_o(rr_grant)
`ifdef AXI_RD_ARB_PERFCNT_EN
        , .perf_gnt0_o(rr_perf_gnt0), .perf_gnt1_o(rr_perf_gnt1), .perf_stall_o(rr_perf_stall)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Expected grant sequences under continuous contention
    logic [1:0] exp_prio [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [1:0] exp_rr   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one AR from master m, hold slave arready low for ar_wait cycles
    task automatic addr_phase(input int m, input logic [31:0] addr, input logic [7:0] len,
                              input int ar_wait);
        if (m == 0) begin
            m0_arvalid = 1'b1; m0_araddr = addr; m0_arlen = len;
            m0_arsize = 3'd2; m0_arburst = 2'b01;
        end else begin
            m1_arvalid = 1'b1; m1_araddr = addr; m1_arlen = len;
            m1_arsize = 3'd2; m1_arburst = 2'b01;
        end
        #1;
        chk("idle_s_arvalid", {31'b0, s_arvalid}, 0);
        chk("idle_m_arready", {30'b0, m1_arready, m0_arready}, 0);
        step();
        for (int i = 0; i < ar_wait; i++) begin
            s_arready = 1'b0;
            #1;
            chk("hold_arvalid", {31'b0, s_arvalid}, 1);
            chk("hold_araddr", s_araddr, addr);
            chk("hold_arlen", {24'b0, s_arlen}, {24'b0, len});
            chk("hold_m_arready", {30'b0, m1_arready, m0_arready}, 0);
            step();
        end
        s_arready = 1'b1;
        #1;
        chk("ar_valid", {31'b0, s_arvalid}, 1);
        chk("ar_addr", s_araddr, addr);
        chk("ar_len", {24'b0, s_arlen}, {24'b0, len});
        chk("ar_size", {29'b0, s_arsize}, 2);
        chk("ar_burst", {30'b0, s_arburst}, 1);
        chk("ar_grant", {30'b0, grant}, (m == 0) ? 1 : 2);
        chk("ar_m_arready", {30'b0, m1_arready, m0_arready}, (m == 0) ? 1 : 2);
        step();
        s_arready = 1'b0;
        if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        #1;
        chk("data_s_arvalid", {31'b0, s_arvalid}, 0);
        chk("arready_once", {30'b0, m1_arready, m0_arready}, 0);
    endtask

    // Slave returns nbeats; owner drops rready for stall_n cycles at beat stall_at
    task automatic data_phase(input int m, input int nbeats, input int stall_at, input int stall_n);
        int          b       = 0;
        int          got     = 0;
        int          stalled = 0;
        logic        rdy;
        logic [31:0] exp_data;
        for (int cyc = 0; cyc < 64 && b < nbeats; cyc++) begin
            exp_data = 32'hD000_0000 + 32'(m * 256 + b);
            s_rvalid = 1'b1;
            s_rdata  = exp_data;
            s_rresp  = (b % 2 == 1) ? 2'b01 : 2'b00;
            s_rlast  = (b == nbeats - 1);
            rdy      = !(b == stall_at && stalled < stall_n);
            if (!rdy) stalled++;
            if (m == 0) begin m0_rready = rdy; m1_rready = 1'b1; end
            else        begin m1_rready = rdy; m0_rready = 1'b1; end
            #1;
            chk("r_s_rready", {31'b0, s_rready}, {31'b0, rdy});
            chk("r_valid_owner", {31'b0, (m == 0) ? m0_rvalid : m1_rvalid}, 1);
            chk("r_valid_other", {31'b0, (m == 0) ? m1_rvalid : m0_rvalid}, 0);
            chk("r_data", (m == 0) ? m0_rdata : m1_rdata, exp_data);
            chk("r_resp", {30'b0, (m == 0) ? m0_rresp : m1_rresp}, (b % 2 == 1) ? 1 : 0);
            chk("r_last", {31'b0, (m == 0) ? m0_rlast : m1_rlast}, (b == nbeats - 1) ? 1 : 0);
            if ((m == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready)) got++;
            if (s_rready) b++;
            step();
        end
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        chk("r_beat_count", got, nbeats);
        chk("r_end_grant", {30'b0, grant}, 0);
    endtask

    initial begin
        m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m0_rready  = 1'b1; m1_rready = 1'b1;
        s_arready  = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", {30'b0, grant}, 0);
        chk("rst_s_arvalid", {31'b0, s_arvalid}, 0);
        chk("rst_s_rready", {31'b0, s_rready}, 0);
        chk("rst_arready", {30'b0, m1_arready, m0_arready}, 0);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
`ifdef AXI_RD_ARB_PERFCNT_EN
        chk("rst_perf_gnt0", perf_gnt0, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
        rst_n = 1'b1;
        step();

        // single requester m1, 4-beat burst
        addr_phase(1, 32'hC000_0010, 8'd3, 0);
        data_phase(1, 4, -1, 0);

        // continuous contention: priority with starvation guard vs round-robin
        m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; m0_arlen = 8'd0;
        m0_arsize  = 3'd2; m0_arburst = 2'b01;
        m1_arvalid = 1'b1; m1_araddr = 32'h0000_2000; m1_arlen = 8'd0;
        m1_arsize  = 3'd2; m1_arburst = 2'b01;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("turnaround_idle", {31'b0, s_arvalid}, 0);
            step();
            chk("prio_grant", {30'b0, grant}, {30'b0, exp_prio[t]});
            chk("rr_grant", {30'b0, rr_grant}, {30'b0, exp_rr[t]});
            chk("prio_araddr", s_araddr, exp_prio[t][1] ? 32'h0000_2000 : 32'h0000_1000);
            s_arready = 1'b1;
            step();
            s_arready = 1'b0;
            s_rvalid  = 1'b1;
            s_rlast   = 1'b1;
            #1;
            chk("b2b_rready", {31'b0, s_rready}, 1);
            step();
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;

        // slave stalls arready 5 cycles; single-beat burst
        addr_phase(0, 32'h1000_0040, 8'd0, 5);
        data_phase(0, 1, -1, 0);

        // owner drops rready for 3 cycles mid-burst
        addr_phase(0, 32'h2000_0000, 8'd3, 0);
        data_phase(0, 4, 1, 3);

        // reset during beat 2 of an 8-beat burst
        addr_phase(0, 32'h3000_0000, 8'd7, 0);
        s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'hAAAA_0000;
        step();
        s_rdata = 32'hAAAA_0001;
        #1;
        chk("pre_rst_rvalid", {31'b0, m0_rvalid}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 0);
        chk("async_rst_s_rready", {31'b0, s_rready}, 0);
        chk("async_rst_grant", {30'b0, grant}, 0);
        chk("async_rst_s_arvalid", {31'b0, s_arvalid}, 0);
        s_rvalid = 1'b0;
        step();
`ifdef AXI_RD_ARB_PERFCNT_EN
        chk("rst2_perf_gnt0", perf_gnt0, 0);
        chk("rst2_perf_gnt1", perf_gnt1, 0);
        chk("rst2_perf_stall", perf_stall, 0);
`endif
        rst_n = 1'b1;
        step();
        addr_phase(0, 32'h4000_0000, 8'd1, 0);
        data_phase(0, 2, -1, 0);
`ifdef AXI_RD_ARB_PERFCNT_EN
        chk("post_perf_gnt0", perf_gnt0, 1);
        chk("post_perf_gnt1", perf_gnt1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
